// File: rtl/elevator_ctrl_if.sv
// Car-controller bus: debounced floor-call pulses in, car position, motor/door
// status and latched call set out.
interface elevator_ctrl_if #(
  parameter int FLOORS = 4
);
  localparam int FW = (FLOORS > 1) ? $clog2(FLOORS) : 1;

  logic [FLOORS-1:0] call;
  logic [FW-1:0]     floor;
  logic              moving_up;
  logic              moving_down;
  logic              door_open;
  logic [FLOORS-1:0] pending;

  modport master (
    output call,
    input  floor, moving_up, moving_down, door_open, pending
  );

  modport slave (
    input  call,
    output floor, moving_up, moving_down, door_open, pending
  );
endinterface

// File: rtl/elevator_ctrl.sv
// Collective-scheduling elevator car controller: latches floor calls, moves the
// car one floor per TRAVEL_CYCLES, holds the door DOOR_CYCLES at called floors.
module elevator_ctrl #(
  parameter int FLOORS        = 4,
  parameter int TRAVEL_CYCLES = 50,
  parameter int DOOR_CYCLES   = 100
) (
  input  logic            clk,
  input  logic            reset,
  elevator_ctrl_if.slave  bus
);
  localparam int FW   = $clog2(FLOORS);
  localparam int MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LAST   = CW'(DOOR_CYCLES - 1);
  localparam logic [FW-1:0] TOP_FLOOR   = FW'(FLOORS - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_DOOR      = 2'd3
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  state_t            r_state;
  logic [FW-1:0]     r_floor;
  dir_t              r_dir;
  logic [FLOORS-1:0] r_pending;
  logic [CW-1:0]     r_tcnt;
  logic [CW-1:0]     r_dcnt;
  logic              r_moving_up;
  logic              r_moving_down;
  logic              r_door_open;

  state_t            w_state_nxt;
  logic [FW-1:0]     w_floor_nxt;
  dir_t              w_dir_nxt;
  logic [FLOORS-1:0] w_pending_nxt;
  logic [CW-1:0]     w_tcnt_nxt;
  logic [CW-1:0]     w_dcnt_nxt;

  logic              w_above;
  logic              w_below;
  logic              w_ahead;
  logic              w_behind;
  logic [FW-1:0]     w_step_floor;
  logic              w_at_end;

  // State, position, call set and counters; reset discards any trip in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_floor       <= '0;
      r_dir         <= DIR_UP;
      r_pending     <= '0;
      r_tcnt        <= '0;
      r_dcnt        <= '0;
      r_moving_up   <= 1'b0;
      r_moving_down <= 1'b0;
      r_door_open   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_floor       <= w_floor_nxt;
      r_dir         <= w_dir_nxt;
      r_pending     <= w_pending_nxt;
      r_tcnt        <= w_tcnt_nxt;
      r_dcnt        <= w_dcnt_nxt;
      r_moving_up   <= (w_state_nxt == S_MOVE_UP);
      r_moving_down <= (w_state_nxt == S_MOVE_DOWN);
      r_door_open   <= (w_state_nxt == S_DOOR);
    end
  end

  // Outstanding requests relative to the car, and the floor the car is heading to
  always_comb begin
    w_above = 1'b0;
    w_below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      w_above = w_above | (r_pending[i] & (FW'(i) > r_floor));
      w_below = w_below | (r_pending[i] & (FW'(i) < r_floor));
    end
    if (r_dir == DIR_UP) begin
      w_ahead  = w_above;
      w_behind = w_below;
    end else begin
      w_ahead  = w_below;
      w_behind = w_above;
    end
    if (r_state == S_MOVE_DOWN) begin
      w_step_floor = r_floor - FW'(1);
      w_at_end     = (w_step_floor == '0);
    end else begin
      w_step_floor = r_floor + FW'(1);
      w_at_end     = (w_step_floor == TOP_FLOOR);
    end
  end

  // Next-state, call latching and counter control
  always_comb begin
    w_state_nxt   = r_state;
    w_floor_nxt   = r_floor;
    w_dir_nxt     = r_dir;
    w_pending_nxt = r_pending | bus.call;
    w_tcnt_nxt    = r_tcnt;
    w_dcnt_nxt    = r_dcnt;

    case (r_state)
      S_IDLE: begin
        // A call at the car's own floor just opens the door; it is never queued
        w_pending_nxt[r_floor] = r_pending[r_floor];
        if (bus.call[r_floor]) begin
          w_state_nxt = S_DOOR;
          w_dcnt_nxt  = '0;
        end else if (w_above && ((r_dir == DIR_UP) || !w_below)) begin
          w_state_nxt = S_MOVE_UP;
          w_dir_nxt   = DIR_UP;
          w_tcnt_nxt  = '0;
        end else if (w_below) begin
          w_state_nxt = S_MOVE_DOWN;
          w_dir_nxt   = DIR_DOWN;
          w_tcnt_nxt  = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_MOVE_UP, S_MOVE_DOWN: begin
        if (r_tcnt == TRAVEL_LAST) begin
          w_tcnt_nxt  = '0;
          w_floor_nxt = w_step_floor;
          if (r_pending[w_step_floor] || bus.call[w_step_floor]) begin
            w_pending_nxt[w_step_floor] = 1'b0;
            w_state_nxt                 = S_DOOR;
            w_dcnt_nxt                  = '0;
          end else if (w_at_end) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = r_state;
          end
        end else begin
          w_tcnt_nxt = r_tcnt + CW'(1);
        end
      end

      S_DOOR: begin
        w_pending_nxt[r_floor] = r_pending[r_floor];
        if (bus.call[r_floor]) begin
          w_dcnt_nxt = '0;
        end else if (r_dcnt == DOOR_LAST) begin
          w_dcnt_nxt = '0;
          w_tcnt_nxt = '0;
          if (w_ahead) begin
            w_state_nxt = (r_dir == DIR_UP) ? S_MOVE_UP : S_MOVE_DOWN;
          end else if (w_behind) begin
            w_dir_nxt   = (r_dir == DIR_UP) ? DIR_DOWN : DIR_UP;
            w_state_nxt = (r_dir == DIR_UP) ? S_MOVE_DOWN : S_MOVE_UP;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_dcnt_nxt = r_dcnt + CW'(1);
        end
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_pending_nxt = '0;
        w_tcnt_nxt    = '0;
        w_dcnt_nxt    = '0;
      end
    endcase
  end

  assign bus.floor       = r_floor;
  assign bus.pending     = r_pending;
  assign bus.moving_up   = r_moving_up;
  assign bus.moving_down = r_moving_down;
  assign bus.door_open   = r_door_open;
endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench for elevator_ctrl: directed scenarios plus random calls,
// all compared cycle by cycle against a countdown-based behavioural model.
module tb_elevator_ctrl;
  localparam int F = 4;
  localparam int T = 4;
  localparam int D = 3;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  elevator_ctrl_if #(.FLOORS(F)) bus ();

  elevator_ctrl #(
    .FLOORS(F),
    .TRAVEL_CYCLES(T),
    .DOOR_CYCLES(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: motion is -1/0/+1, door/travel are remaining-cycle counts
  int       m_floor;
  int       m_dir;
  int       m_motion;
  int       m_door_left;
  int       m_travel_left;
  bit [3:0] m_pending;

  task automatic model_step(input logic [3:0] c, input bit rst);
    bit [3:0] old;
    bit [3:0] np;
    bit       ab;
    bit       bl;
    bit       ahead;
    bit       behind;
    if (rst) begin
      m_floor = 0; m_dir = 1; m_motion = 0;
      m_door_left = 0; m_travel_left = 0; m_pending = 4'b0;
      return;
    end
    old = m_pending;
    np  = old;
    ab  = 1'b0;
    bl  = 1'b0;
    for (int i = 0; i < F; i++) begin
      if (old[i] && i > m_floor) ab = 1'b1;
      if (old[i] && i < m_floor) bl = 1'b1;
    end
    if (m_door_left > 0) begin
      for (int i = 0; i < F; i++) if (c[i] && i != m_floor) np[i] = 1'b1;
      if (c[m_floor]) m_door_left = D;
      else if (m_door_left == 1) begin
        m_door_left = 0;
        ahead  = (m_dir == 1) ? ab : bl;
        behind = (m_dir == 1) ? bl : ab;
        if (ahead) begin
          m_motion = m_dir; m_travel_left = T;
        end else if (behind) begin
          m_dir = -m_dir; m_motion = m_dir; m_travel_left = T;
        end
      end else m_door_left--;
    end else if (m_motion != 0) begin
      np = old | c;
      if (m_travel_left == 1) begin
        m_floor += m_motion;
        if (old[m_floor] || c[m_floor]) begin
          np[m_floor] = 1'b0; m_motion = 0; m_door_left = D; m_travel_left = 0;
        end else m_travel_left = T;
      end else m_travel_left--;
    end else begin
      for (int i = 0; i < F; i++) if (c[i] && i != m_floor) np[i] = 1'b1;
      if (c[m_floor]) m_door_left = D;
      else if (ab && (m_dir == 1 || !bl)) begin
        m_dir = 1; m_motion = 1; m_travel_left = T;
      end else if (bl) begin
        m_dir = -1; m_motion = -1; m_travel_left = T;
      end
    end
    m_pending = np;
  endtask

  function automatic logic [8:0] exp_vec();
    return {2'(m_floor), (m_motion == 1), (m_motion == -1), (m_door_left > 0), m_pending};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {bus.floor, bus.moving_up, bus.moving_down, bus.door_open, bus.pending};
  endfunction

  task automatic tick(input logic [3:0] v);
    bus.call = v;
    @(posedge clk);
    model_step(v, reset);
    #1;
    bus.call = 4'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(4'b0);
    tick(4'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (dut_vec() !== 9'b0) begin
      bad++; $display("FAIL reset_state got=%b exp=%b", dut_vec(), 9'b0);
    end
    for (int k = 0; k < 3; k++) begin
      tick(4'b0);
      total++;
      if (dut_vec() !== 9'b0) begin
        bad++; $display("FAIL reset_idle k=%0d got=%b exp=%b", k, dut_vec(), 9'b0);
      end
    end
  endtask

  task automatic test_single_call();
    int ups;
    int doors;
    bit done;
    do_reset();
    tick(4'b1000);
    total++;
    if (bus.pending !== 4'b1000) begin
      bad++; $display("FAIL single_latch got=%b exp=%b", bus.pending, 4'b1000);
    end
    ups = 0; doors = 0; done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      tick(4'b0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL single_cycle k=%0d got=%b exp=%b", k, dut_vec(), exp_vec());
      end
      ups   += int'(bus.moving_up);
      doors += int'(bus.door_open);
      if (!bus.moving_up && !bus.moving_down && !bus.door_open && bus.pending == 4'b0) done = 1'b1;
    end
    total++;
    if (!done) begin bad++; $display("FAIL single_timeout got=busy exp=idle"); end
    total++;
    if (ups != 12) begin bad++; $display("FAIL single_up_cycles got=%0d exp=12", ups); end
    total++;
    if (doors != 3) begin bad++; $display("FAIL single_door_cycles got=%0d exp=3", doors); end
    total++;
    if (bus.floor !== 2'd3) begin bad++; $display("FAIL single_floor got=%0d exp=3", bus.floor); end
  endtask

  task automatic test_mid_travel_stop();
    int  stops[$];
    bit  prev_door;
    bit  done;
    do_reset();
    tick(4'b1000);
    tick(4'b0);
    tick(4'b0010);
    prev_door = 1'b0; done = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      tick(4'b0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL midstop_cycle k=%0d got=%b exp=%b", k, dut_vec(), exp_vec());
      end
      if (bus.door_open && !prev_door) stops.push_back(int'(bus.floor));
      prev_door = bus.door_open;
      if (!bus.moving_up && !bus.moving_down && !bus.door_open && bus.pending == 4'b0) done = 1'b1;
    end
    total++;
    if (!done || stops.size() != 2 || stops[0] != 1 || stops[1] != 3) begin
      bad++; $display("FAIL midstop_order got=%p exp='{1, 3}", stops);
    end
  endtask

  task automatic test_reverse();
    int  stops[$];
    int  downs;
    bit  prev_door;
    bit  done;
    do_reset();
    tick(4'b1000);
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      tick(4'b0);
      if (bus.floor == 2'd2) done = 1'b1;
    end
    total++;
    if (!done || !bus.moving_up) begin
      bad++; $display("FAIL reverse_reach2 got=floor%0d up=%b exp=floor2 up=1", bus.floor, bus.moving_up);
    end
    tick(4'b0001);
    prev_door = 1'b0; done = 1'b0; downs = 0;
    for (int k = 0; k < 80 && !done; k++) begin
      tick(4'b0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL reverse_cycle k=%0d got=%b exp=%b", k, dut_vec(), exp_vec());
      end
      downs += int'(bus.moving_down);
      if (bus.door_open && !prev_door) stops.push_back(int'(bus.floor));
      prev_door = bus.door_open;
      if (!bus.moving_up && !bus.moving_down && !bus.door_open && bus.pending == 4'b0) done = 1'b1;
    end
    total++;
    if (!done || stops.size() != 2 || stops[0] != 3 || stops[1] != 0) begin
      bad++; $display("FAIL reverse_order got=%p exp='{3, 0}", stops);
    end
    total++;
    if (downs != 12) begin bad++; $display("FAIL reverse_down_cycles got=%0d exp=12", downs); end
    total++;
    if (m_dir != -1) begin bad++; $display("FAIL reverse_model_dir got=%0d exp=-1", m_dir); end
  endtask

  task automatic test_door_restart();
    int open_after;
    bit done;
    do_reset();
    tick(4'b0010);
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      tick(4'b0);
      if (bus.door_open) done = 1'b1;
    end
    total++;
    if (!done || bus.floor !== 2'd1) begin
      bad++; $display("FAIL restart_arrive got=floor%0d door=%b exp=floor1 door=1", bus.floor, bus.door_open);
    end
    for (int p = 0; p < 3; p++) begin
      tick(4'b0010);
      total++;
      if (dut_vec() !== exp_vec() || bus.pending[1] !== 1'b0 || !bus.door_open) begin
        bad++; $display("FAIL restart_pulse p=%0d got=%b exp=%b", p, dut_vec(), exp_vec());
      end
      if (p < 2) begin
        tick(4'b0);
        total++;
        if (dut_vec() !== exp_vec() || !bus.door_open) begin
          bad++; $display("FAIL restart_gap p=%0d got=%b exp=%b", p, dut_vec(), exp_vec());
        end
      end
    end
    open_after = 0;
    for (int k = 0; k < 10 && bus.door_open; k++) begin
      open_after++;
      tick(4'b0);
    end
    total++;
    if (open_after != 3) begin bad++; $display("FAIL restart_close got=%0d exp=3", open_after); end
  endtask

  task automatic test_reset_mid_travel();
    bit done;
    do_reset();
    tick(4'b1010);
    tick(4'b0);
    tick(4'b0);
    total++;
    if (bus.pending !== 4'b1010 || !bus.moving_up) begin
      bad++; $display("FAIL midreset_pre got=%b up=%b exp=1010 up=1", bus.pending, bus.moving_up);
    end
    reset = 1'b1;
    tick(4'b0);
    reset = 1'b0;
    total++;
    if (dut_vec() !== 9'b0) begin
      bad++; $display("FAIL midreset_clear got=%b exp=%b", dut_vec(), 9'b0);
    end
    tick(4'b0100);
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      tick(4'b0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL midreset_cycle k=%0d got=%b exp=%b", k, dut_vec(), exp_vec());
      end
      if (!bus.moving_up && !bus.moving_down && !bus.door_open && bus.pending == 4'b0) done = 1'b1;
    end
    total++;
    if (!done || bus.floor !== 2'd2) begin
      bad++; $display("FAIL midreset_serve got=floor%0d exp=floor2", bus.floor);
    end
  endtask

  task automatic test_random();
    logic [3:0] v;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      v = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      tick(v);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_cycle k=%0d call=%b got=%b exp=%b", k, v, dut_vec(), exp_vec());
      end
      total++;
      if ((int'(bus.moving_up) + int'(bus.moving_down) + int'(bus.door_open)) > 1 ||
          (bus.moving_up && bus.floor == 2'd3) || (bus.moving_down && bus.floor == 2'd0)) begin
        bad++; $display("FAIL random_bounds k=%0d got=%b exp=exclusive,in-range", k, dut_vec());
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.call = 4'b0;
    test_reset();
    test_single_call();
    test_mid_travel_stop();
    test_reverse();
    test_door_restart();
    test_reset_mid_travel();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
